// File: rtl/hamm_encoder_tx_pkg.sv
// Hamming(8,4) shared definitions: FSM states and parity masks,
// common to the serial encoder and the matching decoder.
package hamm_encoder_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  // Data bits covered by each parity bit cw[1], cw[2], cw[3].
  localparam logic [3:0] P1_MASK = 4'b1011;
  localparam logic [3:0] P2_MASK = 4'b1101;
  localparam logic [3:0] P3_MASK = 4'b1110;

endpackage

// File: rtl/hamm84_parity.sv
// Combinational Hamming(8,4) codeword builder with overall
// even parity in bit 0.
module hamm84_parity
  import hamm_encoder_tx_pkg::*;
(
  input  logic [3:0] d,
  output logic [7:0] cw
);

  logic [2:0] p;

  assign p[0] = ^(d & P1_MASK);
  assign p[1] = ^(d & P2_MASK);
  assign p[2] = ^(d & P3_MASK);
  assign cw   = {d, p[2], p[1], p[0], ^{d, p}};

endmodule

// File: rtl/hamm_encoder_tx.sv
// Hamming(8,4) encoder with a double-buffered serial transmitter:
// holding register feeds an 8-bit shifter, optional inter-word gap.
module hamm_encoder_tx
  import hamm_encoder_tx_pkg::*;
#(
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       tx_en,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       tx_sof,
  output logic [7:0] cw_out,
  output logic       busy
);

  localparam logic [3:0] GAP_LAST =
    (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state, state_n;
  logic [7:0] hold, shreg, cw_new;
  logic       hfull;
  logic [2:0] cnt;
  logic [3:0] gcnt;
  logic       accept, load, step, last;

  hamm84_parity u_par (
    .d (in_data),
    .cw(cw_new)
  );

  assign in_ready = ~hfull;
  assign accept   = in_valid & ~hfull;
  assign step     = (state == ST_SEND) & tx_en;
  assign last     = step & (cnt == 3'd7);
  assign tx_valid = step;
  assign tx_sof   = step & (cnt == 3'd0);
  assign tx_bit   = step &
    (MSB_FIRST ? shreg[7] : shreg[0]);
  assign busy     = (state != ST_IDLE) | hfull;

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (hfull) begin
          load    = 1'b1;
          state_n = ST_SEND;
        end
      end
      ST_SEND: begin
        if (last) begin
          if (GAP > 0) begin
            state_n = ST_GAP;
          end else if (hfull) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gcnt == GAP_LAST) begin
          if (hfull) begin
            load    = 1'b1;
            state_n = ST_SEND;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold   <= 8'h00;
      hfull  <= 1'b0;
      shreg  <= 8'h00;
      cw_out <= 8'h00;
      cnt    <= 3'd0;
      gcnt   <= 4'd0;
    end else begin
      if (accept) begin
        hold <= cw_new;
      end
      // Old content leaves on load while a new word may arrive.
      hfull <= (hfull & ~load) | accept;
      if (load) begin
        shreg  <= hold;
        cw_out <= hold;
        cnt    <= 3'd0;
      end else if (step) begin
        shreg <= MSB_FIRST ? {shreg[6:0], 1'b0}
                           : {1'b0, shreg[7:1]};
        cnt   <= cnt + 3'd1;
      end
      if (state == ST_GAP && state_n == ST_GAP) begin
        gcnt <= gcnt + 4'd1;
      end else begin
        gcnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_hamm_encoder_tx.sv
// Scoreboard bench: three encoder instances (GAP=0 LSB, GAP=3,
// MSB-first) driven by directed and random nibbles.
module tb_hamm_encoder_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_en = 1'b1;
  logic [3:0] in_data [3];
  logic       in_valid [3];
  logic       in_ready [3];
  logic       tx_bit [3];
  logic       tx_valid [3];
  logic       tx_sof [3];
  logic [7:0] cw_out [3];
  logic       busy [3];

  int errors = 0;
  int checks = 0;
  logic [1:0] expq [3][$];
  logic [7:0] cwq [3][$];
  int vcnt [3];
  int run [3];
  int maxrun [3];
  int idle [3];
  int lastgap [3];
  logic [1:0] mon_e;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hamm_encoder_tx #(
      .GAP      (g == 1 ? 3 : 0),
      .MSB_FIRST(g == 2 ? 1'b1 : 1'b0)
    ) u (
      .clk     (clk),
      .reset   (reset),
      .in_data (in_data[g]),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .tx_en   (tx_en),
      .tx_bit  (tx_bit[g]),
      .tx_valid(tx_valid[g]),
      .tx_sof  (tx_sof[g]),
      .cw_out  (cw_out[g]),
      .busy    (busy[g])
    );
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference codeword straight from the bit mapping rules.
  function automatic logic [7:0] ref_cw(input logic [3:0] d);
    logic [7:0] c;
    c[7:4] = d;
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[0] = ($countones(c[7:1]) % 2) == 1;
    return c;
  endfunction

  task automatic expect_cw(input int g, input logic [7:0] cw);
    cwq[g].push_back(cw);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = (g == 2) ? 7 - i : i;
      expq[g].push_back({i == 0, cw[k]});
    end
  endtask

  task automatic send(input int g, input logic [3:0] d,
                      input logic [7:0] cw);
    int n;
    n = 0;
    in_data[g]  = d;
    in_valid[g] = 1'b1;
    while (!in_ready[g] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[g]) begin
      chk("accept_timeout", 0, 1);
      in_valid[g] = 1'b0;
      return;
    end
    expect_cw(g, cw);
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && (busy[0] || busy[1] || busy[2] ||
           expq[0].size() != 0 || expq[1].size() != 0 ||
           expq[2].size() != 0)) begin
      @(posedge clk); #1;
      n++;
    end
    for (int g = 0; g < 3; g++) begin
      chk("drain_queue", expq[g].size(), 0);
      chk("drain_busy", busy[g], 0);
    end
  endtask

  task automatic wait_bits(input int g, input int target);
    int n;
    n = 0;
    while (vcnt[g] < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bit_timeout", vcnt[g] >= target, 1);
  endtask

  task automatic check_reset_vals();
    for (int g = 0; g < 3; g++) begin
      chk("rst_in_ready", in_ready[g], 1);
      chk("rst_tx_valid", tx_valid[g], 0);
      chk("rst_tx_sof", tx_sof[g], 0);
      chk("rst_tx_bit", tx_bit[g], 0);
      chk("rst_cw_out", cw_out[g], 8'h00);
      chk("rst_busy", busy[g], 0);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int g = 0; g < 3; g++) begin
        if (tx_valid[g]) begin
          chk("valid_needs_en", tx_en, 1);
          if (expq[g].size() == 0) begin
            chk("unexpected_bit", 1, 0);
          end else begin
            mon_e = expq[g].pop_front();
            chk("tx_bit", tx_bit[g], mon_e[0]);
            chk("tx_sof", tx_sof[g], mon_e[1]);
            if (mon_e[1]) begin
              lastgap[g] = idle[g];
              if (cwq[g].size() == 0)
                chk("cw_missing", 1, 0);
              else
                chk("cw_out", cw_out[g], cwq[g].pop_front());
            end
          end
          vcnt[g]++;
          run[g]++;
          if (run[g] > maxrun[g]) maxrun[g] = run[g];
          idle[g] = 0;
        end else begin
          chk("sof_without_valid", tx_sof[g], 0);
          run[g] = 0;
          idle[g]++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int mark;
    logic [3:0] r;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0;
      in_data[g]  = 4'h0;
      vcnt[g] = 0; run[g] = 0; maxrun[g] = 0;
      idle[g] = 0; lastgap[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b1;
    @(posedge clk); #1;

    // Known vectors and first-bit latency.
    send(0, 4'h0, 8'h00);
    chk("busy_after_accept", busy[0], 1);
    @(negedge clk);
    chk("lat_cycle1_valid", tx_valid[0], 0);
    @(negedge clk);
    chk("lat_cycle2_sof", tx_sof[0], 1);
    wait_idle(200);
    send(0, 4'h1, 8'h17);
    wait_idle(200);
    send(0, 4'hB, 8'hB2);
    wait_idle(200);
    send(0, 4'hF, 8'hFF);
    wait_idle(200);

    // Back-to-back at GAP=0.
    maxrun[0] = 0;
    r = 4'($urandom());
    send(0, r, ref_cw(r));
    r = 4'($urandom());
    send(0, r, ref_cw(r));
    chk("ready_low_both_full", in_ready[0], 0);
    r = 4'($urandom());
    send(0, r, ref_cw(r));
    wait_idle(300);
    chk("b2b_run", maxrun[0], 24);

    // Inter-word gap of 3 cycles.
    lastgap[1] = -1;
    r = 4'($urandom());
    send(1, r, ref_cw(r));
    r = 4'($urandom());
    send(1, r, ref_cw(r));
    wait_idle(300);
    chk("gap_len", lastgap[1], 3);

    // Pause the line for 5 cycles mid-codeword.
    start = vcnt[0];
    send(0, 4'hB, 8'hB2);
    wait_bits(0, start + 3);
    tx_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("en_low_valid", tx_valid[0], 0);
    end
    @(posedge clk); #1;
    tx_en = 1'b1;
    wait_idle(300);
    chk("en_bit_total", vcnt[0] - start, 8);

    // Reset mid-codeword with a second nibble held.
    start = vcnt[0];
    send(0, 4'hF, 8'hFF);
    r = 4'($urandom());
    send(0, r, ref_cw(r));
    wait_bits(0, start + 3);
    reset = 1'b0;
    #1;
    check_reset_vals();
    for (int g = 0; g < 3; g++) begin
      expq[g].delete();
      cwq[g].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    mark = vcnt[0];
    repeat (20) @(posedge clk);
    #1;
    chk("no_residual_bits", vcnt[0] - mark, 0);
    chk("no_residual_busy", busy[0], 0);

    // MSB-first instance.
    send(2, 4'h1, 8'h17);
    wait_idle(200);

    // Randomized traffic on all instances with a flickering line.
    for (int g = 0; g < 3; g++) begin
      automatic int gg = g;
      fork
        begin
          for (int i = 0; i < 8; i++) begin
            automatic logic [3:0] d = 4'($urandom());
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
            send(gg, d, ref_cw(d));
          end
        end
      join_none
    end
    fork
      begin
        repeat (300) begin
          @(posedge clk); #1;
          tx_en = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    wait fork;
    tx_en = 1'b1;
    wait_idle(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamm_encoder_tx.md
HAMM_ENCODER_TX -- requirements
Module: hamm_encoder_tx

Interface
REQ-001 The block SHALL take parameter GAP, default 0: idle cycles inserted between consecutive serialized codewords, range 0..15.
REQ-002 The block SHALL take parameter MSB_FIRST, default 0: 0 sends codeword bit 0 first, 1 sends bit 7 first.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  4  data nibble to encode.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  the holding register can accept a nibble.
REQ-008 tx_en  input  1  line enable; when low, serialization pauses.
REQ-009 tx_bit  output  1  serial codeword bit.
REQ-010 tx_valid  output  1  tx_bit carries a codeword bit this cycle.
REQ-011 tx_sof  output  1  marks the first bit of each codeword.
REQ-012 cw_out  output  8  the codeword most recently loaded into the shifter.
REQ-013 busy  output  1  the holding register or the shifter is occupied.

Function
REQ-014 Codeword mapping SHALL be: cw[7:4]=d[3:0]; cw[1]=d0^d1^d3; cw[2]=d0^d2^d3; cw[3]=d1^d2^d3; cw[0]=XOR of cw[7:1] (overall even parity).
REQ-015 The handshake SHALL be: a nibble is accepted on a rising edge where in_valid&in_ready=1; in_ready=1 exactly when the holding register is empty.
REQ-016 The codeword SHALL be computed at acceptance and stored in the holding register, so the shifter never recomputes parity.
REQ-017 The FSM SHALL have states IDLE, SEND and GAP.
REQ-018 IDLE->SEND SHALL occur on the edge after the holding register becomes full: the holding register moves to the shifter, the bit counter resets to 0 and cw_out updates.
REQ-019 In SEND, on each cycle with tx_en=1, the block SHALL assert tx_valid=1, drive tx_bit with the current bit and advance the counter on the following edge.
REQ-020 When tx_en=0, tx_valid SHALL be 0 and the counter and shifter SHALL hold.
REQ-021 tx_sof SHALL be 1 only while tx_valid=1 and counter=0.
REQ-022 After bit 7 is sent with GAP=0 and the holding register full, the shifter SHALL reload on the same edge, giving back-to-back codewords with no bubble.
REQ-023 After bit 7 is sent with GAP=0 and the holding register empty, the FSM SHALL go to IDLE.
REQ-024 After bit 7 is sent with GAP>0, the FSM SHALL enter GAP and count GAP cycles (the count advances regardless of tx_en), then go to SEND if the holding register is full, otherwise to IDLE.
REQ-025 The holding register SHALL accept a new nibble during SEND or GAP (double buffering).
REQ-026 An accept and a shifter reload on the same edge SHALL be legal: the old content moves to the shifter and the new nibble is written.
REQ-027 Latency: with the block idle and tx_en=1, the first bit (tx_sof=1) SHALL appear 2 cycles after the accepting edge.
REQ-028 Throughput at GAP=0 SHALL be one nibble per 8 enabled cycles; in_ready SHALL stay low while both stages are full.
REQ-029 busy SHALL be 0 only in IDLE with the holding register empty.

Reset
REQ-030 When reset=0, all state SHALL clear asynchronously: FSM=IDLE, counters=0, holding register empty, shifter=0.
REQ-031 Output values under reset SHALL be: in_ready=1, tx_valid=0, tx_sof=0, tx_bit=0, cw_out=8'h00, busy=0.
REQ-032 Reset asserted mid-codeword SHALL drop the partial codeword and the held nibble; after release, no residual bits are sent.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the parity-mask constants, for reuse with the matching decoder.
REQ-034 The parity computation SHALL be a combinational sub-module, hamm84_parity, used once here.

Verification
REQ-035 A bench SHALL cover: reset, then nibbles 4'h0, 4'h1, 4'hB, 4'hF -> cw_out 8'h00, 8'h17, 8'hB2, 8'hFF; serial LSB-first for 4'hB is 0,1,0,0,1,1,0,1.
REQ-036 A bench SHALL cover: GAP=0, in_valid held high with 3 nibbles -> 24 consecutive tx_valid cycles, tx_sof at cycles 0, 8 and 16.
REQ-037 A bench SHALL cover: GAP=3 with 2 nibbles -> 3 tx_valid=0 cycles between bit 7 and the next tx_sof.
REQ-038 A bench SHALL cover: tx_en low for 5 cycles mid-codeword -> tx_valid=0 and bit order preserved on resume, total still 8 bits.
REQ-039 A bench SHALL cover: reset asserted at bit 3 of 4'hF with a second nibble held -> outputs at reset values immediately, no further tx_valid after release until a new accept.
REQ-040 A bench SHALL cover: MSB_FIRST=1 with 4'h1 -> serial 0,0,0,1,0,1,1,1.
